// File: rtl/div16_if.sv
`default_nettype none
// ============================================================================
// Module      : div16_if
// Description : Start/done handshake and operand/result bundle for div16.
// Revision    : 1.0 - initial release
// ============================================================================
interface div16_if #(
    parameter int N = 16
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             done;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, done, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, done, div_by_zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/div16.sv
`default_nettype none
// ============================================================================
// Module      : div16
// Description : Unsigned restoring divider, 2N/N -> N quotient + N remainder,
//               one quotient bit per clock with start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module div16 #(
    parameter int N = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    div16_if.slave    bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ITER  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N:0]      r_q, r_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    divisor_q, divisor_d;
    logic [CW-1:0]   count_q, count_d;
    logic [N-1:0]    quotient_q, quotient_d;
    logic [N-1:0]    remainder_q, remainder_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [N+1:0]    w_shift;
    logic [N+1:0]    w_trial;
    logic            w_bit;
    logic [N:0]      w_r_next;
    logic [N-1:0]    w_q_next;

    // R stays below the divisor, so its top bit is always zero and the
    // N+2-bit trial difference carries the sign in its MSB.
    always_comb begin
        w_shift  = {r_q, q_q[N-1]};
        w_trial  = w_shift - {2'b00, divisor_q};
        w_bit    = ~w_trial[N+1];
        w_r_next = w_bit ? w_trial[N:0] : w_shift[N:0];
        w_q_next = {q_q[N-2:0], w_bit};
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        divisor_d   = divisor_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = done_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        if (bus.start) begin
            divisor_d = bus.divisor;
            r_d       = {1'b0, bus.dividend[2*N-1:N]};
            q_d       = bus.dividend[N-1:0];
            count_d   = '0;
            done_d    = 1'b0;
            dbz_d     = 1'b0;
            ovf_d     = 1'b0;
            state_d   = S_CHECK;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_CHECK: begin
                    // q_q still holds the dividend's low half at this point
                    if (divisor_q == '0) begin
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = q_q;
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                    end else if (r_q >= {1'b0, divisor_q}) begin
                        ovf_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = q_q;
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_ITER;
                    end
                end
                S_ITER: begin
                    r_d     = w_r_next;
                    q_d     = w_q_next;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(N - 1)) begin
                        quotient_d  = w_q_next;
                        remainder_d = w_r_next[N-1:0];
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b1;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            divisor_q   <= divisor_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_div16.sv
`default_nettype none
// ============================================================================
// Module      : tb_div16
// Description : Directed and product-based checks for the div16 divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div16;
    localparam int N = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    div16_if #(.N(N)) bus ();

    div16 #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents operands at a negedge; returns 1ns after the start edge (E0).
    task automatic do_start(input logic [31:0] dvd, input logic [15:0] dvs);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_edges, output int edges);
        edges = 0;
        while (edges < max_edges) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                          input logic [15:0] exp_q, input logic [15:0] exp_r);
        int edges;
        do_start(dvd, dvs);
        check({tag, "_busy"}, 64'(bus.done), 64'd0);
        wait_done(40, edges);
        check({tag, "_lat"}, 64'(edges), 64'd17);
        check({tag, "_q"}, 64'(bus.quotient), 64'(exp_q));
        check({tag, "_r"}, 64'(bus.remainder), 64'(exp_r));
        check({tag, "_flags"}, 64'({bus.div_by_zero, bus.overflow}), 64'd0);
    endtask

    initial begin
        int            edges;
        logic [15:0]   a, b, rm;
        logic [31:0]   dvd;

        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        #1;
        check("rst_done", 64'(bus.done), 64'd1);
        check("rst_q", 64'(bus.quotient), 64'd0);
        check("rst_r", 64'(bus.remainder), 64'd0);
        check("rst_flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("idle_hold", 64'({bus.done, bus.quotient, bus.remainder}), {31'd0, 1'b1, 32'd0});

        run_op("d1000_7", 32'd1000, 16'd7, 16'd142, 16'd6);
        run_op("dmax", 32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000);
        run_op("d10000_2", 32'h0001_0000, 16'h0002, 16'h8000, 16'h0000);
        run_op("div1", 32'h0000_BEEF, 16'h0001, 16'hBEEF, 16'h0000);

        // Divide by zero, then overflow: both resolve by E2.
        do_start(32'h1234_5678, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("dbz_done", 64'(bus.done), 64'd1);
        check("dbz_flag", 64'({bus.div_by_zero, bus.overflow}), 64'b10);
        check("dbz_q", 64'(bus.quotient), 64'hFFFF);
        check("dbz_r", 64'(bus.remainder), 64'h5678);

        do_start(32'h0002_0000, 16'h0002);
        check("ovf_clr", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_done", 64'(bus.done), 64'd1);
        check("ovf_flag", 64'({bus.div_by_zero, bus.overflow}), 64'b01);
        check("ovf_q", 64'(bus.quotient), 64'hFFFF);
        check("ovf_r", 64'(bus.remainder), 64'h0000);

        // Restart mid-operation at E5.
        do_start(32'd100, 16'd3);
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy", 64'(bus.done), 64'd0);
        do_start(32'd50000, 16'd250);
        wait_done(40, edges);
        check("abort_lat", 64'(edges), 64'd17);
        check("abort_q", 64'(bus.quotient), 64'd200);
        check("abort_r", 64'(bus.remainder), 64'd0);

        // start held high keeps re-arming.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 16'd7;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("hold_busy", 64'(bus.done), 64'd0);
        end
        bus.start = 1'b0;
        wait_done(40, edges);
        check("hold_lat", 64'(edges), 64'd17);
        check("hold_q", 64'(bus.quotient), 64'd142);

        // Asynchronous reset mid-operation.
        do_start(32'd1000, 16'd7);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_done", 64'(bus.done), 64'd1);
        check("arst_q", 64'(bus.quotient), 64'd0);
        check("arst_r", 64'(bus.remainder), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("d21_4", 32'd21, 16'd4, 16'd5, 16'd1);

        // Products with a known remainder: dividend = a*b + rm, rm < b.
        for (int k = 0; k < 50; k++) begin
            a   = 16'($urandom);
            b   = 16'($urandom_range(1, 65535));
            rm  = 16'($urandom_range(0, int'(b) - 1));
            dvd = 32'(a) * 32'(b) + 32'(rm);
            run_op("rnd", dvd, b, a, rm);
            check("rnd_inv", 64'(bus.quotient) * 64'(b) + 64'(bus.remainder), 64'(dvd));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
